// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - round-robin writeback port sharing with busy scoreboard
module regfile_wb_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic [ADDR_W-1:0] issue_src1,
    input  logic [ADDR_W-1:0] issue_src2,
    output logic              issue_ready,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_dest,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [NREG-1:0]   busy,
    output logic              wb_err
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_MEM = 1'b1
    } rr_t;

    rr_t               rr_ptr;
    logic              accept;
    logic              issue_fire;
    logic [ADDR_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   busy_next;

    always_comb begin
        alu_ready = alu_valid && (!mem_valid || rr_ptr == PTR_ALU);
        mem_ready = mem_valid && (!alu_valid || rr_ptr == PTR_MEM);
        accept    = alu_ready || mem_ready;
        wb_dest   = alu_ready ? alu_dest : mem_dest;
        wb_data   = alu_ready ? alu_data : mem_data;
    end

    always_comb begin
        issue_ready = !busy[issue_src1] && !busy[issue_src2] && !busy[issue_dest];
        issue_fire  = issue_valid && issue_ready;
        set_mask    = issue_fire  ? (NREG'(1) << issue_dest)    : '0;
        clr_mask    = rf_write_en ? (NREG'(1) << rf_write_dest) : '0;
        // Clear is applied first so a same-edge set on the same register survives.
        busy_next   = (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_write_en   <= 1'b0;
            rf_write_dest <= '0;
            rf_write_data <= '0;
            busy          <= '0;
            wb_err        <= 1'b0;
            rr_ptr        <= PTR_ALU;
        end else begin
            rf_write_en <= accept;
            wb_err      <= accept && !busy[wb_dest];
            busy        <= busy_next;
            if (accept) begin
                rf_write_dest <= wb_dest;
                rf_write_data <= wb_data;
                rr_ptr        <= alu_ready ? PTR_MEM : PTR_ALU;
            end
        end
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the single write port of the 8x16 register file between two writeback requesters (ALU and memory), using round-robin arbitration and valid/ready handshakes.
- Keeps a per-register busy scoreboard so the issue stage stalls on RAW and WAW hazards until the pending result is in the array.
- Sits between the execute/memory stages and the register file write port; its rf_* outputs drive the register file directly.

Parameters:
- DATA_W, 16, writeback data width.
- ADDR_W, 3, register index width.
- NREG, 8, number of registers (2**ADDR_W).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- alu_valid  input  1  ALU writeback request.
- alu_dest  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- alu_ready  output  1  ALU request accepted this cycle.
- mem_valid  input  1  memory writeback request.
- mem_dest  input  ADDR_W  memory destination register.
- mem_data  input  DATA_W  load data.
- mem_ready  output  1  memory request accepted this cycle.
- issue_valid  input  1  instruction wants to issue.
- issue_dest  input  ADDR_W  destination it will write.
- issue_src1  input  ADDR_W  first source register.
- issue_src2  input  ADDR_W  second source register.
- issue_ready  output  1  no hazard; issue accepted when issue_valid is also high.
- rf_write_en  output  1  register file write enable.
- rf_write_dest  output  ADDR_W  register file write index.
- rf_write_data  output  DATA_W  register file write data.
- busy  output  NREG  scoreboard, bit i set means register i has a pending write.
- wb_err  output  1  one-cycle pulse: accepted writeback targeted a non-busy register.

Behaviour:
Clock and reset
- Single clock domain.
- Reset is synchronous and active-low, sampled on the clk rising edge.
- While rst_n=0 (including mid-operation), at the next edge: rf_write_en=0, rf_write_dest=0, rf_write_data=0, busy=0, wb_err=0, rr_ptr=ALU.
- Any in-flight writeback is discarded on reset.

Arbitration
- alu_ready, mem_ready and issue_ready are combinational.
- Only one requester valid: that requester gets ready=1.
- Both valid: the requester selected by rr_ptr gets ready=1, the other gets 0.
- After every accept, rr_ptr points to the requester that was not granted. It does not change in idle cycles.
- At most one of alu_ready and mem_ready is high in any cycle.
- A requester must hold valid, dest and data stable until it sees ready. The bench checks this; the block does not.

Write port (1-cycle latency)
- Accept in cycle t: in cycle t+1, rf_write_en=1 and rf_write_dest/rf_write_data carry the registered dest and data.
- The register file array updates at the edge ending cycle t+1.
- With no accept in cycle t, rf_write_en=0 in t+1. dest/data hold their last value.
- Back-to-back accepts give rf_write_en=1 on consecutive cycles, sustaining one write per cycle.

Scoreboard
- issue_ready = !busy[issue_src1] & !busy[issue_src2] & !busy[issue_dest]. It does not depend on issue_valid.
- Set: issue accepted (issue_valid & issue_ready) in cycle t sets busy[issue_dest] at the edge ending t.
- Clear: busy[d] clears at the same edge the array is written (end of t+1 for an accept in t). An issue in cycle t+2 reading d sees the new data.
- There is no bypass: issue_ready stays 0 during cycle t+1 for d.
- If set and clear hit the same register at the same edge, set wins. This can only happen after an erroneous writeback.
- wb_err pulses in cycle t+1 if the writeback accepted in cycle t had busy[dest]=0 at acceptance. The write still proceeds.
- Writes to register 0 are treated the same as any other register. There is no hardwired zero.

Test Plan:
- Reset, then idle -> busy=0, rf_write_en=0, issue_ready=1 for any sources; asserting rst_n=0 mid-writeback clears busy and suppresses rf_write_en at the next edge.
- Issue dest=3 at t, then issue src1=3 at t+1 -> busy[3]=1 and issue_ready=0; ALU writes 16'h00AA to r3 at t+2 -> rf_write_en=1 with dest 3 and data 00AA at t+3; busy[3]=0 and issue_ready=1 from t+4.
- Both requesters valid for 4 cycles (ALU dest 1, MEM dest 2) -> grants alternate ALU, MEM, ALU, MEM starting from the reset priority, one rf write per cycle, no ready overlap.
- Only mem_valid for 3 cycles -> mem_ready=1 every cycle; rr_ptr then favours ALU on the next conflict.
- ALU writeback to non-busy r5 -> wb_err pulses for exactly 1 cycle, r5 is still written, busy stays 0.
- WAW: issue dest=4 while busy[4]=1 -> issue_ready=0 until the cycle after r4's write completes.
